// File: rtl/seq_alu.sv
// Sequential ALU: one operation in flight, single-cycle EXEC path and a
// WIDTH-cycle radix-2 Booth multiplier, with NZCV flags held between operations.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW:0]   WIDTH_L  = (SHW + 1)'(WIDTH);

  localparam logic [4:0] OP_ANDS = 5'd1,  OP_ORRS = 5'd2,  OP_MVNS = 5'd3,
                         OP_EORS = 5'd4,  OP_ADCS = 5'd5,  OP_ADDS = 5'd6,
                         OP_SBCS = 5'd7,  OP_SUB  = 5'd8,  OP_MULS = 5'd9,
                         OP_LSRS = 5'd10, OP_LSLS = 5'd11, OP_ASR  = 5'd12,
                         OP_ROR  = 5'd13, OP_UXTB = 5'd14, OP_UXTH = 5'd15,
                         OP_SXTB = 5'd16, OP_SXTH = 5'd17, OP_CMP  = 5'd18;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic signed [WIDTH:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic             qm1_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic [3:0]       flags_q;
  logic             err_q;

  logic accept, mul_last;
  assign accept   = in_valid && (state_q == IDLE);
  assign mul_last = (state_q == MUL) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = (opcode == OP_MULS) ? MUL : EXEC;
        cnt_d   = '0;
      end
      EXEC: state_d = DONE;
      MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Booth step: examine {q0, q-1}, add/subtract multiplicand, arithmetic shift
  logic signed [WIDTH:0] m_ext, booth_sum, acc_nxt;
  logic [WIDTH-1:0]      mq_nxt;

  always_comb begin
    m_ext = {a_q[WIDTH-1], a_q};
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    acc_nxt = booth_sum >>> 1;
    mq_nxt  = {booth_sum[0], mq_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= opcode;
      a_q   <= num1;
      b_q   <= num2;
      acc_q <= '0;
      mq_q  <= num2;
      qm1_q <= 1'b0;
    end else if (state_q == MUL) begin
      acc_q <= acc_nxt;
      mq_q  <= mq_nxt;
      qm1_q <= mq_q[0];
    end
  end

  // Single-cycle EXEC datapath
  logic [SHW-1:0]   sh;
  logic [SHW:0]     rot_amt;
  logic             is_sub, cin, add_v;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_full, lsl_full, lsr_full;
  logic signed [WIDTH:0] asr_full;
  logic [WIDTH-1:0] ror_res;

  always_comb begin
    sh       = b_q[SHW-1:0];
    rot_amt  = WIDTH_L - {1'b0, sh};
    is_sub   = (op_q == OP_SUB) || (op_q == OP_SBCS) || (op_q == OP_CMP);
    cin      = ((op_q == OP_ADCS) || (op_q == OP_SBCS)) ? flags_q[2] : is_sub;
    add_b    = is_sub ? ~b_q : b_q;
    add_full = {1'b0, a_q} + {1'b0, add_b} + (WIDTH + 1)'(cin);
    add_v    = (a_q[WIDTH-1] == add_b[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
    lsl_full = {1'b0, a_q} << sh;
    lsr_full = {a_q, 1'b0} >> sh;
    asr_full = $signed({a_q, 1'b0}) >>> sh;
    ror_res  = (a_q >> sh) | (a_q << rot_amt);
  end

  logic [WIDTH-1:0] exec_res, fsrc;
  logic             exec_c, exec_v, nz_upd, exec_err;
  logic [3:0]       exec_flags;

  always_comb begin
    exec_res = '0;
    exec_c   = flags_q[2];
    exec_v   = flags_q[3];
    nz_upd   = 1'b1;
    exec_err = 1'b0;
    fsrc     = '0;
    case (op_q)
      OP_ANDS: exec_res = a_q & b_q;
      OP_ORRS: exec_res = a_q | b_q;
      OP_EORS: exec_res = a_q ^ b_q;
      OP_MVNS: exec_res = ~a_q;
      OP_ADDS, OP_ADCS, OP_SUB, OP_SBCS: begin
        exec_res = add_full[WIDTH-1:0];
        exec_c   = add_full[WIDTH];
        exec_v   = add_v;
      end
      OP_CMP: begin
        exec_c = add_full[WIDTH];
        exec_v = add_v;
      end
      OP_LSLS: begin
        exec_res = lsl_full[WIDTH-1:0];
        if (sh != '0) exec_c = lsl_full[WIDTH];
      end
      OP_LSRS: begin
        exec_res = lsr_full[WIDTH:1];
        if (sh != '0) exec_c = lsr_full[0];
      end
      OP_ASR: begin
        exec_res = asr_full[WIDTH:1];
        if (sh != '0) exec_c = asr_full[0];
      end
      OP_ROR: begin
        exec_res = (sh == '0) ? a_q : ror_res;
        if (sh != '0) exec_c = ror_res[WIDTH-1];
      end
      OP_UXTB: begin exec_res = {{(WIDTH-8){1'b0}}, a_q[7:0]};      nz_upd = 1'b0; end
      OP_UXTH: begin exec_res = {{(WIDTH-16){1'b0}}, a_q[15:0]};    nz_upd = 1'b0; end
      OP_SXTB: begin exec_res = {{(WIDTH-8){a_q[7]}}, a_q[7:0]};    nz_upd = 1'b0; end
      OP_SXTH: begin exec_res = {{(WIDTH-16){a_q[15]}}, a_q[15:0]}; nz_upd = 1'b0; end
      default: begin exec_err = 1'b1; nz_upd = 1'b0; end
    endcase
    // CMP reports flags of the difference while its result reads zero
    fsrc       = (op_q == OP_CMP) ? add_full[WIDTH-1:0] : exec_res;
    exec_flags = nz_upd ? {exec_v, exec_c, (fsrc == '0), fsrc[WIDTH-1]} : flags_q;
  end

  // Result/flag registers load only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else if (state_q == EXEC) begin
      result_q    <= exec_res;
      result_hi_q <= '0;
      flags_q     <= exec_flags;
      err_q       <= exec_err;
    end else if (mul_last) begin
      result_q    <= mq_nxt;
      result_hi_q <= acc_nxt[WIDTH-1:0];
      flags_q     <= {flags_q[3:2], (mq_nxt == '0), mq_nxt[WIDTH-1]};
      err_q       <= 1'b0;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: hand-computed vectors, latency, back-pressure and reset abort.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   opcode = '0;
  logic [W-1:0] num1 = '0, num2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result, result_hi;
  logic [3:0]   flags;
  logic         err;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .num1(num1), .num2(num2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    opcode = op; num1 = a; num2 = b; in_valid = 1'b1;
    check({tag, "_rdy"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output int busy);
    lat = 0; busy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire(input string tag);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check({tag, "_ovclr"}, 64'(out_valid), 64'(0));
    check({tag, "_rdyback"}, 64'(in_ready), 64'(1));
  endtask

  typedef struct {
    string        name;
    logic [4:0]   op;
    logic [W-1:0] a, b, res, hi;
    logic [3:0]   fl;
    logic         er;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    int lat, busy;
    issue(v.name, v.op, v.a, v.b);
    wait_result(lat, busy);
    check({v.name, "_lat"},   64'(lat),       64'(v.lat));
    check({v.name, "_busy"},  64'(busy),      64'(0));
    check({v.name, "_res"},   64'(result),    64'(v.res));
    check({v.name, "_hi"},    64'(result_hi), 64'(v.hi));
    check({v.name, "_flags"}, 64'(flags),     64'(v.fl));
    check({v.name, "_err"},   64'(err),       64'(v.er));
    retire(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, busy, seen;

    vecs.push_back(vec_t'{"adds_wrap", 5'd6,  32'hFFFFFFFF, 32'h1, 32'h0,        32'h0, 4'b0110, 1'b0, 1});
    vecs.push_back(vec_t'{"sub_neg",   5'd8,  32'h5,        32'h7, 32'hFFFFFFFE, 32'h0, 4'b0001, 1'b0, 1});
    vecs.push_back(vec_t'{"sbcs_c0",   5'd7,  32'hA,        32'h3, 32'h6,        32'h0, 4'b0100, 1'b0, 1});
    vecs.push_back(vec_t'{"muls_m1x2", 5'd9,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b0101, 1'b0, W});
    vecs.push_back(vec_t'{"adds_1p1",  5'd6,  32'h1,        32'h1, 32'h2,        32'h0, 4'b0000, 1'b0, 1});
    vecs.push_back(vec_t'{"lsrs_1",    5'd10, 32'h80000001, 32'h1, 32'h40000000, 32'h0, 4'b0100, 1'b0, 1});
    vecs.push_back(vec_t'{"lsrs_0",    5'd10, 32'h80000000, 32'h0, 32'h80000000, 32'h0, 4'b0101, 1'b0, 1});
    vecs.push_back(vec_t'{"cmp",       5'd18, 32'h5,        32'h3, 32'h0,        32'h0, 4'b0100, 1'b0, 1});
    vecs.push_back(vec_t'{"adcs_c1",   5'd5,  32'h1,        32'h2, 32'h4,        32'h0, 4'b0000, 1'b0, 1});
    vecs.push_back(vec_t'{"ror_1",     5'd13, 32'h1,        32'h1, 32'h80000000, 32'h0, 4'b0101, 1'b0, 1});
    vecs.push_back(vec_t'{"asr_4",     5'd12, 32'h80000000, 32'h4, 32'hF8000000, 32'h0, 4'b0001, 1'b0, 1});
    vecs.push_back(vec_t'{"lsls_1",    5'd11, 32'h80000001, 32'h1, 32'h2,        32'h0, 4'b0100, 1'b0, 1});
    vecs.push_back(vec_t'{"sxtb",      5'd16, 32'h12345680, 32'h0, 32'hFFFFFF80, 32'h0, 4'b0100, 1'b0, 1});
    vecs.push_back(vec_t'{"uxth",      5'd15, 32'hFFFF8001, 32'h0, 32'h00008001, 32'h0, 4'b0100, 1'b0, 1});
    vecs.push_back(vec_t'{"mvns",      5'd3,  32'h0,        32'h0, 32'hFFFFFFFF, 32'h0, 4'b0101, 1'b0, 1});
    vecs.push_back(vec_t'{"eors_z",    5'd4,  32'hAAAA5555, 32'hAAAA5555, 32'h0, 32'h0, 4'b0110, 1'b0, 1});
    vecs.push_back(vec_t'{"adds_ovf",  5'd6,  32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 4'b1001, 1'b0, 1});
    vecs.push_back(vec_t'{"muls_7xm3", 5'd9,  32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1001, 1'b0, W});
    vecs.push_back(vec_t'{"muls_hi",   5'd9,  32'h00010000, 32'h00010000, 32'h0, 32'h1, 4'b1010, 1'b0, W});

    // Reset state
    #1;
    check("rst_ov",    64'(out_valid), 64'(0));
    check("rst_res",   64'(result),    64'(0));
    check("rst_flags", 64'(flags),     64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy",   64'(in_ready),  64'(1));
    check("rst_hi",    64'(result_hi), 64'(0));
    check("rst_err",   64'(err),       64'(0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: hold DONE for 5 cycles with a competing request
    issue("stall", 5'd1, 32'h0000F0F0, 32'h0000FF00);
    wait_result(lat, busy);
    check("stall_lat", 64'(lat), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin opcode = 5'd6; num1 = 32'h1; num2 = 32'h1; in_valid = 1'b1; end
      if (i == 3) in_valid = 1'b0;
      check("stall_ov",    64'(out_valid), 64'(1));
      check("stall_res",   64'(result),    64'(32'h0000F000));
      check("stall_flags", 64'(flags),     64'(4'b1000));
    end
    retire("stall");
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("stall_no_ghost", 64'(seen),   64'(0));
    check("stall_res_kept", 64'(result), 64'(32'h0000F000));

    // Reset at MUL cycle 10 aborts the multiply
    issue("mul_abort", 5'd9, 32'h1234, 32'h5678);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ov",    64'(out_valid), 64'(0));
    check("abort_res",   64'(result),    64'(0));
    check("abort_hi",    64'(result_hi), 64'(0));
    check("abort_flags", 64'(flags),     64'(0));
    check("abort_err",   64'(err),       64'(0));
    @(negedge clk) rst_n = 1'b1;
    #1 check("abort_rdy", 64'(in_ready), 64'(1));
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_ov", 64'(seen), 64'(0));

    // Unsupported opcode keeps flags
    run_vec(vec_t'{"adds_pre", 5'd6,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0110, 1'b0, 1});
    run_vec(vec_t'{"bad_op25", 5'd25, 32'h12345678, 32'h9, 32'h0, 32'h0, 4'b0110, 1'b1, 1});
    run_vec(vec_t'{"bad_op0",  5'd0,  32'h1,        32'h1, 32'h0, 32'h0, 4'b0110, 1'b1, 1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
